// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// Optional build macro MEM_ARB_DM_PRIORITY_EN: fixed data-port priority.
package mem_arb_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_IF) ? OWN_DM : OWN_IF;
  endfunction

endpackage : mem_arb_pkg

// File: rtl/rr_arb2.sv
// Two-way picker between fetch and data ports with combinational grants.
// MEM_ARB_DM_PRIORITY_EN selects fixed data priority instead of round-robin.
module rr_arb2
  import mem_arb_pkg::*;
(
`ifndef MEM_ARB_DM_PRIORITY_EN
  input  logic clk,
`endif
  input  logic rstn,
  input  logic i_req_if,
  input  logic i_req_dm,
  output logic o_gnt_if,
  output logic o_gnt_dm
);

  logic w_pick_dm;

`ifdef MEM_ARB_DM_PRIORITY_EN
  assign w_pick_dm = i_req_dm;
`else
  owner_e r_last_owner;

  // Resets to DM so the very first contended cycle favours the fetch port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last_owner <= OWN_DM;
    end else if (o_gnt_if) begin
      r_last_owner <= OWN_IF;
    end else if (o_gnt_dm) begin
      r_last_owner <= OWN_DM;
    end
  end

  assign w_pick_dm = i_req_dm &&
                     (!i_req_if || (other_owner(r_last_owner) == OWN_DM));
`endif

  // Grants are masked during reset so nothing reaches the RAM.
  assign o_gnt_dm = rstn && w_pick_dm;
  assign o_gnt_if = rstn && i_req_if && !w_pick_dm;

endmodule : rr_arb2

// File: rtl/mem_arbiter.sv
// Shares one single-port 1-cycle-latency RAM between fetch and data ports.
// Build macro MEM_ARB_DM_PRIORITY_EN gives the data port fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic            clk,
  input  logic            rstn,

  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,

  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_wmask,
  output logic            dm_gnt,
  output logic            dm_rvalid,
  output logic [DW-1:0]   dm_rdata,

  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic [DW-1:0]   mem_rdata,

  output logic            if_stall,
  output logic            dm_stall
);

  logic   w_gnt_if;
  logic   w_gnt_dm;
  logic   r_pending;
  owner_e r_owner;

  rr_arb2 u_picker (
`ifndef MEM_ARB_DM_PRIORITY_EN
    .clk      (clk),
`endif
    .rstn     (rstn),
    .i_req_if (if_req),
    .i_req_dm (dm_req),
    .o_gnt_if (w_gnt_if),
    .o_gnt_dm (w_gnt_dm)
  );

  assign if_gnt   = w_gnt_if;
  assign dm_gnt   = w_gnt_dm;
  assign if_stall = if_req && !w_gnt_if;
  assign dm_stall = dm_req && !w_gnt_dm;

  // The RAM port follows the winner; fetch can never write.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (w_gnt_dm) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      mem_wmask = dm_wmask;
    end else if (w_gnt_if) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
    end
  end

  // One outstanding read at most, since RAM latency is exactly one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pending <= 1'b0;
      r_owner   <= OWN_IF;
    end else begin
      r_pending <= w_gnt_if || (w_gnt_dm && !dm_we);
      if (w_gnt_if || w_gnt_dm) begin
        r_owner <= w_gnt_dm ? OWN_DM : OWN_IF;
      end
    end
  end

  assign if_rvalid = r_pending && (r_owner == OWN_IF);
  assign dm_rvalid = r_pending && (r_owner == OWN_DM);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; follows the DUT build macro
// MEM_ARB_DM_PRIORITY_EN when deciding which port wins contended cycles.
module tb_mem_arbiter;

`ifdef MEM_ARB_DM_PRIORITY_EN
  localparam bit DmPrio = 1'b1;
`else
  localparam bit DmPrio = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wmask;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        if_stall;
  logic        dm_stall;

  int compared;
  int mismatched;

  mem_arbiter dut (
    .clk       (clk),
    .rstn      (rstn),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_wmask  (dm_wmask),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rdata (mem_rdata),
    .if_stall  (if_stall),
    .dm_stall  (dm_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                               input logic dmReq, input logic dmWe,
                               input logic [31:0] dmAddr, input logic [31:0] dmWdata,
                               input logic [3:0] dmWmask);
    if_req   = ifReq;
    if_addr  = ifAddr;
    dm_req   = dmReq;
    dm_we    = dmWe;
    dm_addr  = dmAddr;
    dm_wdata = dmWdata;
    dm_wmask = dmWmask;
  endtask

  initial begin
    bit expDm;
    bit prevDm;
    compared   = 0;
    mismatched = 0;
    rstn       = 1'b0;
    mem_rdata  = 32'h0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset: requests present but nothing may be granted or returned.
    @(negedge clk);
    applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    mem_rdata = 32'hFFFF_FFFF;
    #1;
    checkOutput("rst_if_gnt", if_gnt, 0);
    checkOutput("rst_dm_gnt", dm_gnt, 0);
    checkOutput("rst_mem_en", mem_en, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    @(negedge clk);
    #1;
    checkOutput("rst_if_rvalid", if_rvalid, 0);
    checkOutput("rst_dm_rvalid", dm_rvalid, 0);
    checkOutput("rst_if_rdata", if_rdata, 0);
    checkOutput("rst_dm_rdata", dm_rdata, 0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rstn = 1'b1;

    // Lone fetch read at 0x10, data 0x13 returned one cycle later.
    @(negedge clk);
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    checkOutput("if_gnt", if_gnt, 1);
    checkOutput("if_dm_gnt", dm_gnt, 0);
    checkOutput("if_mem_en", mem_en, 1);
    checkOutput("if_mem_addr", mem_addr, 32'h10);
    checkOutput("if_mem_we", mem_we, 0);
    checkOutput("if_stall", if_stall, 0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    mem_rdata = 32'h0000_0013;
    #1;
    checkOutput("if_rvalid", if_rvalid, 1);
    checkOutput("if_rdata", if_rdata, 32'h13);
    checkOutput("if_dm_rvalid", dm_rvalid, 0);
    checkOutput("if_dm_rdata", dm_rdata, 0);
    checkOutput("idle_mem_en", mem_en, 0);
    checkOutput("idle_mem_we", mem_we, 0);

    // Fetch just owned the RAM, so a contended cycle goes to data.
    @(negedge clk);
    applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    #1;
    checkOutput("ct_dm_gnt", dm_gnt, 1);
    checkOutput("ct_if_gnt", if_gnt, 0);
    checkOutput("ct_if_stall", if_stall, 1);
    checkOutput("ct_mem_addr", mem_addr, 32'h200);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    mem_rdata = 32'hA5A5_0001;
    #1;
    checkOutput("ct_dm_rvalid", dm_rvalid, 1);
    checkOutput("ct_dm_rdata", dm_rdata, 32'hA5A5_0001);
    checkOutput("ct_if_rvalid", if_rvalid, 0);
    checkOutput("ct_if_rdata", if_rdata, 0);

    // Fresh reset, then both ports read every cycle with no bubbles.
    @(negedge clk);
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    prevDm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 32'h40 + 32'(4 * i), 1'b1, 1'b0, 32'h300 + 32'(4 * i),
                    32'h0, 4'h0);
      mem_rdata = 32'h1000 + 32'(i);
      expDm = DmPrio ? 1'b1 : (i % 2 == 1);
      #1;
      checkOutput($sformatf("rr%0d_if_gnt", i), if_gnt, !expDm);
      checkOutput($sformatf("rr%0d_dm_gnt", i), dm_gnt, expDm);
      checkOutput($sformatf("rr%0d_mem_en", i), mem_en, 1);
      checkOutput($sformatf("rr%0d_mem_addr", i), mem_addr,
                  expDm ? 32'h300 + 32'(4 * i) : 32'h40 + 32'(4 * i));
      checkOutput($sformatf("rr%0d_if_stall", i), if_stall, expDm);
      checkOutput($sformatf("rr%0d_dm_stall", i), dm_stall, !expDm);
      if (i > 0) begin
        checkOutput($sformatf("rr%0d_if_rvalid", i), if_rvalid, !prevDm);
        checkOutput($sformatf("rr%0d_dm_rvalid", i), dm_rvalid, prevDm);
        checkOutput($sformatf("rr%0d_rdata", i), prevDm ? dm_rdata : if_rdata,
                    32'h1000 + 32'(i));
        checkOutput($sformatf("rr%0d_other_rdata", i), prevDm ? if_rdata : dm_rdata, 0);
      end
      prevDm = expDm;
    end

    // Data write contended with a fetch; data last owned the RAM.
    @(negedge clk);
    applyStimulus(1'b1, 32'h50, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
    #1;
    checkOutput("wr_a_if_gnt", if_gnt, !DmPrio);
    checkOutput("wr_a_dm_stall", dm_stall, !DmPrio);
    checkOutput("wr_a_mem_we", mem_we, DmPrio);
    checkOutput("wr_a_mem_addr", mem_addr, DmPrio ? 32'h100 : 32'h50);
    checkOutput("wr_a_mem_wmask", mem_wmask, DmPrio ? 4'hF : 4'h0);
    @(negedge clk);
    if (DmPrio) applyStimulus(1'b1, 32'h50, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    else        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
    mem_rdata = 32'h0000_0077;
    #1;
    checkOutput("wr_b_dm_stall", dm_stall, 0);
    checkOutput("wr_b_mem_en", mem_en, 1);
    checkOutput("wr_b_mem_we", mem_we, !DmPrio);
    checkOutput("wr_b_mem_addr", mem_addr, DmPrio ? 32'h50 : 32'h100);
    checkOutput("wr_b_mem_wdata", mem_wdata, DmPrio ? 32'h0 : 32'hDEAD_BEEF);
    checkOutput("wr_b_mem_wmask", mem_wmask, DmPrio ? 4'h0 : 4'hF);
    checkOutput("wr_b_if_rvalid", if_rvalid, !DmPrio);
    checkOutput("wr_b_dm_rvalid", dm_rvalid, 0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    checkOutput("wr_c_dm_rvalid", dm_rvalid, 0);
    checkOutput("wr_c_if_rvalid", if_rvalid, DmPrio);
    checkOutput("wr_c_mem_en", mem_en, 0);

    // Data read granted, then reset pulsed before the capturing edge.
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h104, 32'h0, 4'h0);
    mem_rdata = 32'hCAFE_F00D;
    #1;
    checkOutput("rd_rst_dm_gnt", dm_gnt, 1);
    checkOutput("rd_rst_mem_addr", mem_addr, 32'h104);
    #1;
    rstn = 1'b0;
    #1;
    checkOutput("rd_rst_gnt_masked", dm_gnt, 0);
    checkOutput("rd_rst_en_masked", mem_en, 0);
    #1;
    rstn = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("rd_rst%0d_dm_rvalid", i), dm_rvalid, 0);
      checkOutput($sformatf("rd_rst%0d_dm_rdata", i), dm_rdata, 0);
      checkOutput($sformatf("rd_rst%0d_mem_en", i), mem_en, 0);
    end

    // After that reset the first contended cycle is the fetch port's.
    @(negedge clk);
    applyStimulus(1'b1, 32'h60, 1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
    #1;
    checkOutput("post_rst_if_gnt", if_gnt, !DmPrio);
    checkOutput("post_rst_dm_gnt", dm_gnt, DmPrio);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32, byte-address width of all address ports.
REQ-002 Parameter DW, default 32, data width; byte-mask width is DW/8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 if_req  input  1  instruction-fetch read request.
REQ-006 if_addr  input  AW  instruction-fetch byte address.
REQ-007 if_gnt  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid  output  1  fetch read data valid.
REQ-009 if_rdata  output  DW  fetch read data.
REQ-010 dm_req  input  1  data-port request, read or write.
REQ-011 dm_we  input  1  data-port write enable: 1 = write, 0 = read.
REQ-012 dm_addr  input  AW  data-port byte address.
REQ-013 dm_wdata  input  DW  data-port write data.
REQ-014 dm_wmask  input  DW/8  data-port byte-write mask.
REQ-015 dm_gnt  output  1  data request accepted this cycle.
REQ-016 dm_rvalid  output  1  data read data valid.
REQ-017 dm_rdata  output  DW  data read data.
REQ-018 mem_en, mem_we, mem_addr[AW], mem_wdata[DW], mem_wmask[DW/8]  outputs  drive one shared single-port RAM with 1-cycle read latency.
REQ-019 mem_rdata  input  DW  RAM read data, valid the cycle after mem_en=1 with mem_we=0.
REQ-020 if_stall, dm_stall  outputs  1 each  equal req AND NOT gnt, for core pipeline freeze.

Function
REQ-021 Grants SHALL be combinational in the request cycle; at most one of if_gnt/dm_gnt SHALL be high per cycle.
REQ-022 A single requester SHALL always be granted immediately.
REQ-023 With both requesting, the port not granted most recently SHALL win (2-way round-robin); a 1-bit last-owner register SHALL update only on a grant.
REQ-024 On any grant, mem_en=1 and mem_addr/mem_we/mem_wdata/mem_wmask SHALL be taken from the winner; if_* grants force mem_we=0 and mem_wmask=0.
REQ-025 With no grant, mem_en=0 and mem_we=0.
REQ-026 A granted read SHALL register a pending flag and an owner tag; in the next cycle exactly the owner's rvalid is 1 and its rdata equals mem_rdata.
REQ-027 A granted write SHALL produce no rvalid.
REQ-028 Read latency SHALL be 1 cycle; back-to-back grants every cycle SHALL be supported with no bubble.
REQ-029 rdata of the non-owner port SHALL hold 0.
REQ-030 Requests SHALL remain asserted with stable payload until granted; the arbiter SHALL NOT queue requests.

Reset
REQ-031 On rstn low: pending flag = 0, owner tag = IF, last-owner = DM, so the first contended cycle grants IF.
REQ-032 While reset is asserted, all gnt, rvalid, mem_en and mem_we SHALL be 0; rdata outputs SHALL be 0.
REQ-033 Reset asserted with a read pending SHALL drop that read; no rvalid SHALL appear after release.

Configuration
REQ-034 Macro MEM_ARB_DM_PRIORITY_EN defined: the data port SHALL win every contended cycle (fixed priority) and the last-owner register is not built.
REQ-035 Macro undefined: round-robin per REQ-023.

Structure
REQ-036 Package mem_arb_pkg SHALL hold the owner enum (OWN_IF, OWN_DM) and default AW/DW constants.
REQ-037 The 2-way round-robin/priority picker SHALL be a sub-module named rr_arb2.

Verification
REQ-038 if_req only, if_addr=0x10, mem_rdata=0x00000013 -> if_gnt same cycle, mem_en=1, mem_addr=0x10; next cycle if_rvalid=1, if_rdata=0x00000013.
REQ-039 Both req continuously after reset -> grants alternate IF, DM, IF, DM; every cycle has mem_en=1.
REQ-040 dm write addr 0x100, wdata 0xDEADBEEF, wmask 0xF, contended with if_req -> dm_stall=1 for one cycle, then mem_we=1 with those values; dm_rvalid stays 0.
REQ-041 dm read addr 0x104 granted, rstn pulsed low before next edge -> after release, dm_rvalid=0 and mem_en=0 with no requests.
REQ-042 MEM_ARB_DM_PRIORITY_EN defined, both requesting for 4 cycles -> dm_gnt=1 every cycle, if_stall=1 every cycle.
